// File: rtl/data_in_controller.sv
// Streams LENGTH consecutive words from a single-port BRAM onto a valid/ready port.
// Reads are credit-limited so the output FIFO can absorb every in-flight word under backpressure.
module data_in_controller #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 13,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              mem_ena,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W-1:0]   len_reg;
    logic [ADDR_W-1:0]   addr_hold_reg;
    logic [ADDR_W:0]     issued_reg;
    logic [ADDR_W:0]     accepted_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [RD_LAT-1:0]   pipe_reg;
    logic [RD_LAT-1:0]   pipe_next;
    logic [CNT_W-1:0]    fifo_count_reg;
    logic [CNT_W-1:0]    inflight_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [ADDR_W:0]     len_ext;
    logic                issue;
    logic                push;
    logic                pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_ext   = {1'b0, len_reg};
    // Credit counts words buffered plus words still in the BRAM pipeline
    assign issue     = (state_reg == READ) && (issued_reg < len_ext)
                       && ((fifo_count_reg + inflight_reg) < DEPTH_C);
    assign push      = pipe_reg[RD_LAT-1];
    assign pop       = out_valid && out_ready;

    assign mem_ena   = issue;
    assign mem_addr  = issue ? (base_reg + issued_reg[ADDR_W-1:0]) : addr_hold_reg;
    assign out_valid = (fifo_count_reg != '0);
    assign out_data  = fifo_mem[rd_ptr_reg];
    assign busy      = busy_reg;
    assign done      = done_reg;

    assign pipe_next[0] = issue;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
        assign pipe_next[gi] = pipe_reg[gi-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            addr_hold_reg <= '0;
            issued_reg    <= '0;
            accepted_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (pop) accepted_reg <= accepted_reg + 1'b1;
            if (issue) addr_hold_reg <= mem_addr;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg     <= base_addr;
                        len_reg      <= length;
                        issued_reg   <= '0;
                        accepted_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= READ;
                    end
                end
                READ: begin
                    // Zero length is resolved once the latched length is visible
                    if (len_reg == '0) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end else if (issue) begin
                        issued_reg <= issued_reg + 1'b1;
                        if (issued_reg + 1'b1 == len_ext) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (accepted_reg + 1'b1 == len_ext)) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end
                end
                FIN: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_reg       <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            inflight_reg   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            pipe_reg       <= pipe_next;
            fifo_count_reg <= fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
            inflight_reg   <= inflight_reg + CNT_W'(issue) - CNT_W'(push);
            if (push) begin
                fifo_mem[wr_ptr_reg] <= mem_dout;
                wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
            end
            if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (FIFO_DEPTH >= RD_LAT + 2);
            assert (!(push && !pop && fifo_count_reg == DEPTH_C));
        end
    end
endmodule
